ex_divider: RTL and testbench
=============================

# ex_divider

Iterative 32-bit signed/unsigned divider for the EX stage of the Minisys-1A pipeline, executing `div`/`divu`. It accepts operands from the ID/EX register and holds the pipeline with a busy stall request while it iterates. It presents quotient (LO), remainder (HI) and the divide-by-zero flag to the EX/MEM pipeline register in the cycle the instruction is released.

## Interface
Parameters:
- none; widths are fixed by package constants.

Ports:
- `clock`  in  1  — single clock for the block; all state updates on the rising edge.
- `reset`  in  1  — **synchronous, active-high**; the polarity and synchronicity are fixed.
- `flush`  in  1  — synchronous cancel of any in-flight divide.
- `start`  in  1  — request a divide; sampled only in IDLE.
- `sign`  in  1  — 1 = `div` (two's complement), 0 = `divu`; sampled with `start`.
- `dividend`  in  32  — rs value.
- `divisor`  in  32  — rt value.
- `busy`  out  1  — stall request to the pipeline; combinational `start | (state != IDLE)`.
- `done`  out  1  — one-cycle pulse; the result is valid in this cycle.
- `quotient`  out  32  — LO result; registered.
- `remainder`  out  32  — HI result; registered.
- `Divide_zero`  out  1  — set when the completed divide had divisor == 0; feeds `EX_Divide_zero`.

## Operation
States: IDLE, CALC, FIX.

- **IDLE**
  - On `start & !flush`:
    - latch `|dividend|` and `|divisor|` (magnitudes only if `sign`; otherwise raw values);
    - latch both sign bits and the zero-divisor status;
    - clear the partial remainder;
    - set iteration counter = 0;
    - go to CALC.
- **CALC** (restoring division, one quotient bit per cycle)
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor magnitude, subtract it and set the quotient LSB.
  - Counter increments; after iteration 31, go to FIX.
- **FIX**
  - If `sign`:
    - negate the quotient when the dividend and divisor signs differ;
    - negate the remainder when the dividend is negative.
  - Register `quotient`, `remainder` and `Divide_zero`; pulse `done`; go to IDLE.
- **Divide by zero:** `quotient` = 0xFFFFFFFF, `remainder` = original dividend (no sign fix-up), `Divide_zero` = 1.
- **Overflow case** `div 0x80000000 / 0xFFFFFFFF`: `quotient` = 0x80000000, `remainder` = 0, `Divide_zero` = 0. This falls out of 32-bit truncation; no special handling.
- **Result hold:** `quotient`, `remainder` and `Divide_zero` hold until the next completed divide.
- **Ignored inputs:** `start` while not IDLE is ignored. `sign`, `dividend` and `divisor` are don't-care outside the start cycle.

## Timing
- Reset value of every output is 0: `quotient`, `remainder`, `Divide_zero`, `done`. `busy` = 0 when `start` = 0. State returns to IDLE.
- Priority at an edge: `reset` > `flush` > `start`.
- **Latency:**
  - `start` is sampled at edge E0;
  - CALC occupies edges E0+1 … E0+32;
  - FIX registers the result at edge E0+33;
  - `done` is high for the single cycle after E0+33.
- **`busy` span:** high from the start cycle through the cycle before `done`. It is low in the `done` cycle so the EX/MEM register captures the result at the next edge.
- **Back-to-back:** a new `start` may arrive in the `done` cycle and is accepted.
- **Flush:**
  - `flush` in any state → IDLE at that edge;
  - no `done` is produced and the result registers are unchanged;
  - `busy` drops in the next cycle unless a fresh `start` arrives.
- **Reset mid-operation:** aborts at that edge; outputs are 0 in the next cycle.

## Configuration
- Macro: `DIV_ZERO_FASTPATH_EN`.
- **Defined:** in IDLE, `start` with divisor == 0 skips CALC/FIX.
  - The result (0xFFFFFFFF, dividend, `Divide_zero` = 1) is registered at E0.
  - `done` is high in the cycle after E0; `busy` is high only in the start cycle.
- **Undefined:** divide by zero takes the full 33-edge path. The result values are identical to the defined build; only latency differs.

## Structure
- **Package `minisys_div_pkg`:**
  - `DIV_WIDTH` = 32;
  - `DIV_CNT_W` = 6;
  - state enum `div_state_t` {IDLE, CALC, FIX};
  - `DIV_ZERO_QUOT` = 32'hFFFFFFFF.
- **Sub-module `div_restoring_step`:** combinational single-iteration shift/compare/subtract on {rem, quo} and divisor magnitude. The top level holds the FSM, counter, sign latches and output registers.

## Test plan
- **Unsigned divide:** `divu` 100 / 7 → `quotient` 14, `remainder` 2, `Divide_zero` 0. `done` in the cycle after E0+33; `busy` high for the 33 cycles before it.
- **Signed, mixed signs:** `div` 0xFFFFFFF9 (−7) / 2 → `quotient` 0xFFFFFFFD, `remainder` 0xFFFFFFFF. Also `div` 7 / 0xFFFFFFFE → `quotient` 0xFFFFFFFD, `remainder` 1.
- **Overflow case:** `div` 0x80000000 / 0xFFFFFFFF → `quotient` 0x80000000, `remainder` 0, `Divide_zero` 0.
- **Divide by zero:** `div` 5 / 0 → `quotient` 0xFFFFFFFF, `remainder` 5, `Divide_zero` 1. `done` arrives 1 cycle after E0 with `DIV_ZERO_FASTPATH_EN`, or after E0+33 without.
- **Flush mid-operation:** prior result 14/2; `flush` at CALC iteration 10 → no `done`, `quotient`/`remainder` still 14/2, `busy` 0 next cycle. A `start` on the following cycle completes normally.
- **Reset and ignored start:**
  - `reset` at iteration 20 → all outputs 0 next cycle, FSM in IDLE;
  - `start` pulsed during CALC is ignored (exactly one `done`).

Source files
------------

// File: rtl/minisys_div_pkg.sv
// rtl/minisys_div_pkg.sv - shared widths, state encoding and sign helper for the EX-stage divider
package minisys_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    function automatic logic [DIV_WIDTH-1:0] neg_if(
        input logic [DIV_WIDTH-1:0] x,
        input logic                 c
    );
        return c ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one restoring-division iteration on {rem, quo} against the divisor magnitude
module div_restoring_step
    import minisys_div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_in,
    input  logic [DIV_WIDTH-1:0] quo_in,
    input  logic [DIV_WIDTH-1:0] dvsr,
    output logic [DIV_WIDTH-1:0] rem_out,
    output logic [DIV_WIDTH-1:0] quo_out
);

    logic [DIV_WIDTH:0]   rem_sh;
    logic [DIV_WIDTH-1:0] diff;
    logic                 take;

    // rem < dvsr on entry, so the shifted value needs one extra bit but the difference never does
    assign rem_sh  = {rem_in, quo_in[DIV_WIDTH-1]};
    assign take    = (rem_sh >= {1'b0, dvsr});
    assign diff    = rem_sh[DIV_WIDTH-1:0] - dvsr;
    assign rem_out = take ? diff : rem_sh[DIV_WIDTH-1:0];
    assign quo_out = {quo_in[DIV_WIDTH-2:0], take};

endmodule

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - iterative div/divu unit for the EX stage; optional DIV_ZERO_FASTPATH_EN
module ex_divider
    import minisys_div_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 start,
    input  logic                 sign,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 Divide_zero
);

    localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(DIV_WIDTH - 1);

    div_state_t           state;
    div_state_t           state_next;
    logic [DIV_CNT_W-1:0] cnt;
    logic [DIV_WIDTH-1:0] rem;
    logic [DIV_WIDTH-1:0] quo;
    logic [DIV_WIDTH-1:0] dvsr_mag;
    logic [DIV_WIDTH-1:0] rem_step;
    logic [DIV_WIDTH-1:0] quo_step;
    logic                 neg_dd;
    logic                 neg_dv;
    logic                 zero_q;
    logic                 zero_in;
    logic                 done_q;

    assign zero_in = (divisor == '0);
    assign busy    = start | (state != IDLE);
    assign done    = done_q;

    div_restoring_step u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .dvsr    (dvsr_mag),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FASTPATH_EN
                    state_next = zero_in ? IDLE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            quotient    <= '0;
            remainder   <= '0;
            Divide_zero <= 1'b0;
            done_q      <= 1'b0;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr_mag    <= '0;
            neg_dd      <= 1'b0;
            neg_dv      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            quo      <= neg_if(dividend, sign & dividend[DIV_WIDTH-1]);
                            dvsr_mag <= neg_if(divisor, sign & divisor[DIV_WIDTH-1]);
                            neg_dd   <= sign & dividend[DIV_WIDTH-1];
                            neg_dv   <= sign & divisor[DIV_WIDTH-1];
                            zero_q   <= zero_in;
                            rem      <= '0;
                            cnt      <= '0;
`ifdef DIV_ZERO_FASTPATH_EN
                            if (zero_in) begin
                                quotient    <= DIV_ZERO_QUOT;
                                remainder   <= dividend;
                                Divide_zero <= 1'b1;
                                done_q      <= 1'b1;
                            end
`endif
                        end
                    end
                    CALC: begin
                        rem <= rem_step;
                        quo <= quo_step;
                        cnt <= cnt + 1'b1;
                    end
                    FIX: begin
                        // with a zero divisor rem ends as |dividend|, so the normal fix-up restores the raw dividend
                        quotient    <= zero_q ? DIV_ZERO_QUOT : neg_if(quo, neg_dd ^ neg_dv);
                        remainder   <= neg_if(rem, neg_dd);
                        Divide_zero <= zero_q;
                        done_q      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_divider.sv
// tb/tb_ex_divider.sv - randomized scoreboard bench for ex_divider
module tb_ex_divider;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divide_zero;

    res_t exp_q[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_done = 0;

    ex_divider dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .start       (start),
        .sign        (sign),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .Divide_zero (divide_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        res_t   x;
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            x.q  = 32'hFFFF_FFFF;
            x.r  = a;
            x.dz = 1'b1;
            return x;
        end
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        lq   = la / lb;
        lr   = la % lb;
        x.q  = lq[31:0];
        x.r  = lr[31:0];
        x.dz = 1'b0;
        return x;
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FASTPATH_EN
        return (b == 32'd0) ? 1 : 34;
`else
        return 34;
`endif
    endfunction

    // monitor: every done must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 96'(1), 96'(0));
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("result", 96'({quotient, remainder, divide_zero}), 96'(e));
            end
        end
    end

    // called at a negedge; leaves start low shortly after the sampling edge
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
        start    = 1'b1;
        sign     = s;
        dividend = a;
        divisor  = b;
        if (push) begin
            exp_q.push_back(model(s, a, b));
            n_push++;
        end
        @(posedge clock);
        #1;
        start    = 1'b0;
        sign     = $urandom_range(0, 1);
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(input int exp_lat, input int poke);
        int  k;
        bit  got;
        bit  busy_ok;
        got     = 0;
        busy_ok = 1;
        k       = 0;
        while (k < 40 && !got) begin
            @(negedge clock);
            k++;
            if (start) start = 1'b0;
            if (done === 1'b1) begin
                got = 1;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (k == poke) begin
                    start    = 1'b1;
                    sign     = 1'b0;
                    dividend = 32'd999;
                    divisor  = 32'd3;
                end
            end
        end
        if (!got) begin
            check("done_timeout", 96'(0), 96'(1));
        end else begin
            check("latency", 96'(k), 96'(exp_lat));
            check("busy_span", 96'(busy_ok), 96'(1));
            check("busy_low_in_done", 96'(busy), 96'(0));
        end
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        launch(s, a, b, 1);
        wait_done(exp_latency(b), 0);
    endtask

    initial begin
        logic [31:0] pool [5];
        logic [31:0] a;
        logic [31:0] b;
        pool[0] = 32'h0000_0000;
        pool[1] = 32'h0000_0001;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'h7FFF_FFFF;

        reset = 1'b1; flush = 1'b0; start = 1'b0; sign = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 96'({quotient, remainder, divide_zero, done, busy}), 96'(0));
        reset = 1'b0;
        @(negedge clock);

        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd5, 32'd0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div(1'b0, 32'd100, 32'd7);

        // flush at iteration 10 of a divide that never reports
        launch(1'b0, 32'd1000, 32'd3, 0);
        repeat (11) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_busy", 96'(busy), 96'(0));
        check("flush_done", 96'(done), 96'(0));
        check("flush_hold", 96'({quotient, remainder}), 96'({32'd14, 32'd2}));
        run_div(1'b0, 32'd1000, 32'd3);

        // start pulsed mid-CALC must be ignored
        launch(1'b1, 32'hFFFF_0000, 32'd77, 1);
        wait_done(34, 6);
        repeat (40) @(negedge clock);
        check("done_count", 96'(n_done), 96'(n_push));

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            run_div(1'($urandom_range(0, 1)), a, b);
        end

        // reset at iteration 20 clears everything
        launch(1'b1, 32'd12345, 32'd67, 0);
        repeat (21) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_midop", 96'({quotient, remainder, divide_zero, done, busy}), 96'(0));
        run_div(1'b0, 32'd9, 32'd4);

        repeat (40) @(negedge clock);
        check("final_done_count", 96'(n_done), 96'(n_push));
        check("queue_empty", 96'(exp_q.size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
